// File: rtl/mem_stage_ctrl.sv
// MEM-stage SRAM access controller: stalls the pipeline while a load or store
// runs for WAIT_CYCLES SRAM cycles, then releases it for one DONE cycle.
module mem_stage_ctrl #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALURes,
    input  logic [31:0] STVal,
    output logic        freeze,
    output logic [31:0] readData,
    output logic [29:0] SRAM_ADDR,
    output logic [31:0] SRAM_WDATA,
    input  logic [31:0] SRAM_RDATA,
    output logic        SRAM_CE_N,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state_reg;
    logic [3:0] cnt_reg;
    logic       op_write_reg;

    logic req;
    logic is_write;
    logic unused_addr_bits;

    assign req              = MEM_R_EN | MEM_W_EN;
    // A simultaneous load and store request is served as a load.
    assign is_write         = MEM_W_EN & ~MEM_R_EN;
    assign unused_addr_bits = &{1'b0, ALURes[1:0]};

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign freeze = rst & (((state_reg == IDLE) & req) | (state_reg == ACCESS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            op_write_reg <= 1'b0;
            readData     <= 32'd0;
            SRAM_ADDR    <= 30'd0;
            SRAM_WDATA   <= 32'd0;
            SRAM_CE_N    <= 1'b1;
            SRAM_WE_N    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        state_reg    <= ACCESS;
                        cnt_reg      <= CNT_LOAD;
                        op_write_reg <= is_write;
                        SRAM_ADDR    <= ALURes[31:2];
                        SRAM_WDATA   <= STVal;
                        SRAM_CE_N    <= 1'b0;
                        SRAM_WE_N    <= ~is_write;
                    end
                end
                ACCESS: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= DONE;
                        SRAM_CE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        if (!op_write_reg) begin
                            readData <= SRAM_RDATA;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                DONE: begin
                    // Always drop back to IDLE; the pipeline advances during DONE.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (WAIT_CYCLES=3 and WAIT_CYCLES=1).
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] ALURes, STVal, SRAM_RDATA;
    logic        freeze;
    logic [31:0] readData, SRAM_WDATA;
    logic [29:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_WE_N;

    logic        r1;
    logic [31:0] addr1, rdata1;
    logic        freeze1;
    logic [31:0] readData1, wdata1;
    logic [29:0] sram_addr1;
    logic        ce_n1, we_n1;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_rd;

    mem_stage_ctrl #(.WAIT_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALURes(ALURes), .STVal(STVal),
        .freeze(freeze), .readData(readData),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA), .SRAM_RDATA(SRAM_RDATA),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_WE_N(SRAM_WE_N)
    );

    mem_stage_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .MEM_R_EN(r1), .MEM_W_EN(1'b0),
        .ALURes(addr1), .STVal(32'd0),
        .freeze(freeze1), .readData(readData1),
        .SRAM_ADDR(sram_addr1), .SRAM_WDATA(wdata1), .SRAM_RDATA(rdata1),
        .SRAM_CE_N(ce_n1), .SRAM_WE_N(we_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request with a W=3 access and check every cycle up to DONE.
    // The request is left asserted through DONE.
    task automatic run_access(input string tag, input logic r, input logic w,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] rdata, input logic [31:0] exp_rd);
        logic       exp_we;
        logic [29:0] exp_addr;
        exp_we   = ~(w & ~r);
        exp_addr = addr[31:2];
        @(negedge clk);
        MEM_R_EN = r; MEM_W_EN = w; ALURes = addr; STVal = data; SRAM_RDATA = rdata;
        #1;
        check_value({tag, "_idle_freeze"}, 32'(freeze), 32'd1);
        check_value({tag, "_idle_ce_n"}, 32'(SRAM_CE_N), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value($sformatf("%s_acc%0d_freeze", tag, i), 32'(freeze), 32'd1);
            check_value($sformatf("%s_acc%0d_ce_n", tag, i), 32'(SRAM_CE_N), 32'd0);
            check_value($sformatf("%s_acc%0d_we_n", tag, i), 32'(SRAM_WE_N), 32'(exp_we));
            check_value($sformatf("%s_acc%0d_addr", tag, i), 32'(SRAM_ADDR), 32'(exp_addr));
            check_value($sformatf("%s_acc%0d_wdata", tag, i), SRAM_WDATA, data);
            check_value($sformatf("%s_acc%0d_rd", tag, i), readData, last_rd);
        end
        @(negedge clk);
        check_value({tag, "_done_freeze"}, 32'(freeze), 32'd0);
        check_value({tag, "_done_ce_n"}, 32'(SRAM_CE_N), 32'd1);
        check_value({tag, "_done_we_n"}, 32'(SRAM_WE_N), 32'd1);
        check_value({tag, "_done_addr"}, 32'(SRAM_ADDR), 32'(exp_addr));
        check_value({tag, "_done_wdata"}, SRAM_WDATA, data);
        check_value({tag, "_done_rd"}, readData, exp_rd);
        $display("txn %s r=%0d w=%0d addr=0x%08h readData=0x%08h", tag, r, w, addr, readData);
        last_rd = exp_rd;
    endtask

    task automatic drop_request(input string tag);
        @(negedge clk);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        #1;
        check_value({tag, "_idle_nofreeze"}, 32'(freeze), 32'd0);
        check_value({tag, "_idle_ce_n"}, 32'(SRAM_CE_N), 32'd1);
    endtask

    initial begin
        MEM_R_EN = 0; MEM_W_EN = 0; ALURes = 0; STVal = 0; SRAM_RDATA = 0;
        r1 = 0; addr1 = 0; rdata1 = 0;
        last_rd = 32'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check_value("rst_freeze", 32'(freeze), 32'd0);
        check_value("rst_rd", readData, 32'd0);
        check_value("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check_value("rst_wdata", SRAM_WDATA, 32'd0);
        check_value("rst_ce_n", 32'(SRAM_CE_N), 32'd1);
        check_value("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        $display("txn reset readData=0x%08h ce_n=%0d we_n=%0d", readData, SRAM_CE_N, SRAM_WE_N);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Read, then write back-to-back, then a both-enables request served as a read.
        run_access("rd0", 1'b1, 1'b0, 32'h0000_0410, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        check_value("rd0_addr_word", 32'(SRAM_ADDR), 32'h0000_0104);
        run_access("wr0", 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_0000, 32'hDEAD_BEEF);
        check_value("wr0_addr_word", 32'(SRAM_ADDR), 32'h0000_0008);
        run_access("both", 1'b1, 1'b1, 32'h0000_0044, 32'h5A5A_5A5A, 32'h0BAD_CAFE, 32'h0BAD_CAFE);
        drop_request("post_both");

        // Reset two cycles into a write aborts it asynchronously.
        @(negedge clk);
        MEM_W_EN = 1'b1; ALURes = 32'h0000_0030; STVal = 32'h0000_0077;
        @(negedge clk);
        @(negedge clk);
        check_value("abort_pre_we_n", 32'(SRAM_WE_N), 32'd0);
        #2 rst = 1'b0;
        #1;
        check_value("abort_we_n", 32'(SRAM_WE_N), 32'd1);
        check_value("abort_ce_n", 32'(SRAM_CE_N), 32'd1);
        check_value("abort_freeze", 32'(freeze), 32'd0);
        check_value("abort_rd", readData, 32'd0);
        check_value("abort_addr", 32'(SRAM_ADDR), 32'd0);
        $display("txn abort we_n=%0d ce_n=%0d freeze=%0d", SRAM_WE_N, SRAM_CE_N, freeze);
        MEM_W_EN = 1'b0;
        last_rd = 32'd0;
        @(negedge clk);
        rst = 1'b1;

        // Fresh access after reset release.
        run_access("rd1", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 32'h5555_AAAA);
        drop_request("post_rd1");

        // WAIT_CYCLES=1 instance: freeze for 2 cycles, DONE on the 3rd.
        @(negedge clk);
        r1 = 1'b1; addr1 = 32'h0000_0008; rdata1 = 32'hCAFE_F00D;
        #1;
        check_value("w1_idle_freeze", 32'(freeze1), 32'd1);
        @(negedge clk);
        check_value("w1_acc_freeze", 32'(freeze1), 32'd1);
        check_value("w1_acc_ce_n", 32'(ce_n1), 32'd0);
        check_value("w1_acc_rd", readData1, 32'd0);
        check_value("w1_acc_addr", 32'(sram_addr1), 32'd2);
        @(negedge clk);
        check_value("w1_done_freeze", 32'(freeze1), 32'd0);
        check_value("w1_done_ce_n", 32'(ce_n1), 32'd1);
        check_value("w1_done_rd", readData1, 32'hCAFE_F00D);
        $display("txn w1 read addr=0x%08h readData=0x%08h", addr1, readData1);
        r1 = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 3, SRAM access cycles per transfer; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 MEM_R_EN  input  1  load request from the EXE/MEM pipeline register.
REQ-005 MEM_W_EN  input  1  store request from the EXE/MEM pipeline register.
REQ-006 ALURes  input  32  byte address of the access.
REQ-007 STVal  input  32  store data.
REQ-008 freeze  output  1  holds all pipeline registers and PC while high.
REQ-009 readData  output  32  registered load result, to the MEM/WB register.
REQ-010 SRAM_ADDR  output  30  word address to SRAM.
REQ-011 SRAM_WDATA  output  32  write data to SRAM.
REQ-012 SRAM_RDATA  input  32  read data from SRAM.
REQ-013 SRAM_CE_N  output  1  SRAM chip enable, active-low.
REQ-014 SRAM_WE_N  output  1  SRAM write enable, active-low.

Function
REQ-015 States SHALL be IDLE, ACCESS, DONE; 4-bit down-counter cnt.
REQ-016 IDLE: if MEM_R_EN or MEM_W_EN, go ACCESS, load cnt = WAIT_CYCLES-1, latch SRAM_ADDR = ALURes[31:2], SRAM_WDATA = STVal, op = write iff MEM_W_EN and not MEM_R_EN.
REQ-017 MEM_R_EN and MEM_W_EN both high SHALL be treated as a read; write ignored.
REQ-018 ACCESS: SRAM_CE_N = 0; SRAM_WE_N = 0 only for write ops; cnt decrements each cycle.
REQ-019 ACCESS with cnt == 0: go DONE; for reads, readData captures SRAM_RDATA on that edge.
REQ-020 DONE: SRAM_CE_N = 1, SRAM_WE_N = 1, freeze = 0; unconditionally go IDLE next cycle (same still-present request SHALL NOT restart).
REQ-021 freeze SHALL be combinational: high when (IDLE and (MEM_R_EN or MEM_W_EN)) or ACCESS; low otherwise.
REQ-022 Per access freeze SHALL be high for exactly WAIT_CYCLES+1 cycles, then low for the DONE cycle.
REQ-023 Back-to-back accesses: next request seen in IDLE the cycle after DONE; no dead cycle beyond DONE.
REQ-024 readData SHALL hold its value through writes and idle cycles; updates only on read completion.
REQ-025 SRAM_ADDR, SRAM_WDATA SHALL stay constant from ACCESS entry through DONE.
REQ-026 SRAM_CE_N and SRAM_WE_N SHALL be registered outputs (glitch-free).

Reset
REQ-027 rst = 0 SHALL immediately force state IDLE, cnt = 0, readData = 0, SRAM_ADDR = 0, SRAM_WDATA = 0, SRAM_CE_N = 1, SRAM_WE_N = 1, independent of clk.
REQ-028 Reset during ACCESS SHALL abort the transfer: no readData update; SRAM_WE_N returns to 1 asynchronously.
REQ-029 After rst release, first edge with a pending request SHALL start a fresh access per REQ-016.

Verification
REQ-030 WAIT_CYCLES=3, read ALURes=0x0000_0410, SRAM_RDATA=0xDEAD_BEEF -> SRAM_ADDR=0x104, freeze high 4 cycles, readData=0xDEAD_BEEF in DONE, CE_N low 3 cycles.
REQ-031 Write ALURes=0x20, STVal=0x1234_5678 -> SRAM_ADDR=0x8, SRAM_WDATA=0x1234_5678, WE_N low 3 cycles, readData unchanged.
REQ-032 Read then write back-to-back (request held through DONE, new op next cycle) -> two separate 4-cycle freezes separated by one DONE cycle; no duplicated access.
REQ-033 MEM_R_EN=MEM_W_EN=1 -> read performed, WE_N never low.
REQ-034 rst pulled low 2 cycles into a write -> WE_N=1, CE_N=1, freeze=0 within same cycle; readData=0.
REQ-035 WAIT_CYCLES=1 -> freeze high 2 cycles, DONE on 3rd; readData captured correctly.
